// File: rtl/validity_table_pkg.sv
// validity_table_pkg: shared state encoding and occupancy width helper
package validity_table_pkg;
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/validity_query_port.sv
// validity_query_port: one registered lookup channel; indices past DEPTH never match and read 0
module validity_query_port #(
  parameter int DEPTH = 8,
  parameter int IDXW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDXW-1:0]  idx,
  input  logic [DEPTH-1:0] bits,
  output logic             q
);
  logic hit;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) hit = idx == IDXW'(i) ? bits[i] : hit;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= 1'b0;
    else q <= hit;
endmodule

// File: rtl/validity_table.sv
// validity_table: DEPTH valid bits with set/clear ports, NCH query channels,
// occupancy count and a STRIDE-per-cycle flush sweep
module validity_table
  import validity_table_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NCH = 2,
  parameter int IDXW = 3,
  parameter int STRIDE = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          set_en,
  input  logic [IDXW-1:0]               set_idx,
  input  logic                          clr_en,
  input  logic [IDXW-1:0]               clr_idx,
  input  logic [NCH*IDXW-1:0]           q_idx,
  output logic [NCH-1:0]                q_valid,
  input  logic                          flush_req,
  output logic                          flush_busy,
  output logic [occ_width(DEPTH)-1:0]   occupancy,
  output logic                          drop
);
  localparam int OW = occ_width(DEPTH);
  state_t state;
  logic [DEPTH-1:0] bits, nxt;
  logic [IDXW-1:0] ptr;
  logic [OW-1:0] cnt;
  logic set_ok, clr_ok, bad, last;
  assign set_ok = set_en && int'(set_idx) < DEPTH;
  assign clr_ok = clr_en && int'(clr_idx) < DEPTH;
  assign bad = state == SWEEP ? set_en || clr_en : (set_en && !set_ok) || (clr_en && !clr_ok);
  assign last = int'(ptr) + STRIDE >= DEPTH;
  // occupancy is the popcount of the next table, so it tracks every transition exactly
  always_comb begin
    nxt = bits;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = state == SWEEP ? ((i >= int'(ptr) && i < int'(ptr) + STRIDE) ? 1'b0 : bits[i])
             : (set_ok && set_idx == IDXW'(i)) || (!(clr_ok && clr_idx == IDXW'(i)) && bits[i]);
      cnt = cnt + OW'(nxt[i]);
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      bits <= '0;
      ptr <= '0;
      flush_busy <= 1'b0;
      occupancy <= '0;
      drop <= 1'b0;
    end else begin
      bits <= nxt;
      occupancy <= cnt;
      drop <= bad;
      if (state == IDLE) begin
        if (flush_req) begin
          state <= SWEEP;
          ptr <= '0;
          flush_busy <= 1'b1;
        end
      end else if (last) begin
        state <= IDLE;
        flush_busy <= 1'b0;
      end else ptr <= ptr + IDXW'(STRIDE);
    end
  for (genvar c = 0; c < NCH; c++) begin : g_q
    validity_query_port #(.DEPTH(DEPTH), .IDXW(IDXW)) u_q (
      .clk(clk),
      .reset(reset),
      .idx(q_idx[c*IDXW +: IDXW]),
      .bits(bits),
      .q(q_valid[c])
    );
  end
endmodule

// File: tb/tb_validity_table.sv
// tb_validity_table: directed vectors with queued expectations checked by a monitor
module tb_validity_table;
  logic clk = 1'b0, rst_n = 1'b0;
  logic set_en_a = 0, clr_en_a = 0, flush_a = 0, set_en_b = 0, clr_en_b = 0, flush_b = 0;
  logic [2:0] set_idx = 0, clr_idx = 0;
  logic [5:0] q_idx = 0;
  logic [1:0] qv_a, qv_b;
  logic [3:0] occ_a;
  logic [2:0] occ_b;
  logic busy_a, busy_b, drop_a, drop_b;
  int checks = 0, failures = 0;
  int fill_occ[8] = '{3, 4, 5, 5, 5, 6, 7, 8};
  typedef struct {
    bit sel;
    logic [1:0] q;
    logic [3:0] occ;
    logic busy;
    logic drop;
    string name;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  validity_table #(.DEPTH(8), .NCH(2), .IDXW(3), .STRIDE(2)) dut_a (
    .clk(clk), .reset(rst_n), .set_en(set_en_a), .set_idx(set_idx), .clr_en(clr_en_a),
    .clr_idx(clr_idx), .q_idx(q_idx), .q_valid(qv_a), .flush_req(flush_a),
    .flush_busy(busy_a), .occupancy(occ_a), .drop(drop_a));

  validity_table #(.DEPTH(6), .NCH(2), .IDXW(3), .STRIDE(2)) dut_b (
    .clk(clk), .reset(rst_n), .set_en(set_en_b), .set_idx(set_idx), .clr_en(clr_en_b),
    .clr_idx(clr_idx), .q_idx(q_idx), .q_valid(qv_b), .flush_req(flush_b),
    .flush_busy(busy_b), .occupancy(occ_b), .drop(drop_b));

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step(input bit sel, input logic se, input logic [2:0] si, input logic ce,
                      input logic [2:0] ci, input logic fl, input logic [2:0] q0,
                      input logic [2:0] q1, input logic [1:0] eq, input logic [3:0] eocc,
                      input logic ebusy, input logic edrop, input string name);
    exp_t e;
    @(negedge clk);
    set_en_a = !sel && se; set_en_b = sel && se;
    clr_en_a = !sel && ce; clr_en_b = sel && ce;
    flush_a = !sel && fl; flush_b = sel && fl;
    set_idx = si; clr_idx = ci; q_idx = {q1, q0};
    e.sel = sel; e.q = eq; e.occ = eocc; e.busy = ebusy; e.drop = edrop; e.name = name;
    sb.push_back(e);
    @(posedge clk);
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.sel) begin
        chk({e.name, "_q"}, {2'b0, qv_a}, {2'b0, e.q});
        chk({e.name, "_occ"}, occ_a, e.occ);
        chk({e.name, "_busy"}, {3'b0, busy_a}, {3'b0, e.busy});
        chk({e.name, "_drop"}, {3'b0, drop_a}, {3'b0, e.drop});
      end else begin
        chk({e.name, "_q"}, {2'b0, qv_b}, {2'b0, e.q});
        chk({e.name, "_occ"}, {1'b0, occ_b}, e.occ);
        chk({e.name, "_busy"}, {3'b0, busy_b}, {3'b0, e.busy});
        chk({e.name, "_drop"}, {3'b0, drop_b}, {3'b0, e.drop});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_q", {2'b0, qv_a}, 4'd0);
    chk("rst_occ", occ_a, 4'd0);
    chk("rst_busy", {3'b0, busy_a}, 4'd0);
    chk("rst_drop", {3'b0, drop_a}, 4'd0);
    chk("rst_occ_b", {1'b0, occ_b}, 4'd0);
    //   sel se si ce ci fl q0 q1  q  occ busy drop
    step(0, 0, 0, 0, 0, 0, 0, 7, 2'b00, 0, 0, 0, "t1_query");
    step(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, "t2_set1");
    step(0, 1, 5, 0, 0, 0, 1, 5, 2'b01, 2, 0, 0, "t2_set5");
    step(0, 1, 1, 0, 0, 0, 1, 5, 2'b11, 2, 0, 0, "t2_reset1");
    step(0, 0, 0, 0, 0, 0, 1, 5, 2'b11, 2, 0, 0, "t2_query");
    step(0, 1, 3, 1, 3, 0, 3, 3, 2'b00, 3, 0, 0, "t3_setclr_same");
    step(0, 1, 4, 1, 5, 0, 3, 5, 2'b11, 3, 0, 0, "t3_setclr_diff");
    step(0, 0, 0, 0, 0, 0, 4, 5, 2'b01, 3, 0, 0, "t3_query");
    step(0, 0, 0, 1, 1, 0, 1, 6, 2'b01, 2, 0, 0, "t3_clr1");
    step(1, 1, 7, 0, 0, 0, 6, 0, 2'b00, 0, 0, 1, "t4_set_oor");
    step(1, 0, 0, 0, 0, 0, 6, 5, 2'b00, 0, 0, 0, "t4_drop_once");
    step(1, 1, 5, 0, 0, 0, 5, 6, 2'b00, 1, 0, 0, "t4_set5");
    step(1, 0, 0, 1, 6, 0, 5, 6, 2'b01, 1, 0, 1, "t4_clr_oor");
    for (int k = 0; k < 8; k++)
      step(0, 1, 3'(k), 0, 0, 0, 0, 0, k == 0 ? 2'b00 : 2'b11, 4'(fill_occ[k]), 0, 0, "t5_fill");
    step(0, 0, 0, 0, 0, 1, 7, 0, 2'b11, 8, 1, 0, "t5_flush");
    step(0, 0, 0, 0, 0, 0, 0, 7, 2'b11, 6, 1, 0, "t5_sweep1");
    step(0, 1, 0, 0, 0, 0, 0, 2, 2'b10, 4, 1, 1, "t5_sweep2_set");
    step(0, 0, 0, 0, 0, 1, 0, 4, 2'b10, 2, 1, 0, "t5_sweep3_flush");
    step(0, 0, 0, 0, 0, 0, 6, 7, 2'b11, 0, 0, 0, "t5_sweep4");
    step(0, 0, 0, 0, 0, 0, 0, 7, 2'b00, 0, 0, 0, "t5_after");
    step(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, "t6_set1");
    step(0, 1, 2, 0, 0, 0, 0, 0, 2'b00, 2, 0, 0, "t6_set2");
    step(0, 1, 5, 0, 0, 1, 5, 1, 2'b10, 3, 1, 0, "t6_flush_set");
    step(0, 0, 0, 0, 0, 0, 1, 2, 2'b11, 2, 1, 0, "t6_sweep1");
    @(negedge clk);
    rst_n = 1'b0;
    {set_en_a, clr_en_a, flush_a, set_en_b, clr_en_b, flush_b} = '0;
    #1;
    chk("t6_rst_busy", {3'b0, busy_a}, 4'd0);
    chk("t6_rst_occ", occ_a, 4'd0);
    chk("t6_rst_q", {2'b0, qv_a}, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(0, 1, 6, 0, 0, 0, 6, 0, 2'b00, 1, 0, 0, "t6_set6");
    step(0, 0, 0, 0, 0, 0, 6, 2, 2'b01, 1, 0, 0, "t6_query");
    repeat (3) @(posedge clk);
    #2;
    chk("drain", 4'(sb.size()), 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
